// File: rtl/median_filter_pkg.sv
// Shared definitions for the median filter and its writeback stage:
// output geometry helpers, FSM encoding and packed-byte bit order.
package median_filter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Bit 0 of a packed output byte holds the leftmost pixel of its group of 8.
    localparam bit PACK_LSB_LEFTMOST = 1'b1;

    function automatic int calc_out_w(input int image_width, input int window_size);
        return image_width - window_size + 1;
    endfunction

    function automatic int calc_out_h(input int image_height, input int window_size);
        return image_height - window_size + 1;
    endfunction

    function automatic int calc_bytes_per_row(input int out_w);
        return (out_w + 7) / 8;
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Collects 1-bit pixels into bytes; o_byteValid/o_byte are combinational and
// describe the byte completed by the current shift, so the caller registers them.
module pixel_packer
    import median_filter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_shift,
    input  logic       i_bit,
    input  logic       i_flush,
    output logic       o_byteValid,
    output logic [7:0] o_byte
);

    logic [7:0] r_pack;
    logic [2:0] r_idx;
    logic [2:0] w_pos;
    logic [7:0] w_next;

    assign w_pos = PACK_LSB_LEFTMOST ? r_idx : (3'd7 - r_idx);

    always_comb begin
        w_next        = r_pack;
        w_next[w_pos] = i_bit;
    end

    assign o_byte      = w_next;
    assign o_byteValid = i_shift && ((r_idx == 3'd7) || i_flush);

    // A completed byte (full or flushed) restarts packing at bit 0, so a
    // partial byte never carries into the next row.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_pack <= '0;
            r_idx  <= '0;
        end else if (i_shift) begin
            if (o_byteValid) begin
                r_pack <= '0;
                r_idx  <= '0;
            end else begin
                r_pack <= w_next;
                r_idx  <= r_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/median_writeback.sv
// Writeback stage: places median results in raster order, packs rows into
// bytes for the output RAM and flags out-of-order coordinates.
module median_writeback
    import median_filter_pkg::*;
#(
    parameter int WINDOW_SIZE  = 3,
    parameter int IMAGE_WIDTH  = 240,
    parameter int IMAGE_HEIGHT = 180,
    parameter int ADDR_WIDTH   = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  writeEnable,
    input  logic [7:0]            xMedianAddress,
    input  logic [7:0]            yMedianAddress,
    input  logic                  dataIn,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [7:0]            memData,
    output logic                  busy,
    output logic                  frameDone,
    output logic                  sequenceError
);

    localparam int OUT_W         = calc_out_w(IMAGE_WIDTH, WINDOW_SIZE);
    localparam int OUT_H         = calc_out_h(IMAGE_HEIGHT, WINDOW_SIZE);
    localparam int BYTES_PER_ROW = calc_bytes_per_row(OUT_W);

    localparam logic [7:0]            LAST_X   = 8'(OUT_W - 1);
    localparam logic [7:0]            LAST_Y   = 8'(OUT_H - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(BYTES_PER_ROW);

    state_t                r_state;
    state_t                w_nextState;
    logic [7:0]            r_expX;
    logic [7:0]            r_expY;
    logic [ADDR_WIDTH-1:0] r_rowBase;

    logic                  w_accept;
    logic                  w_startFrame;
    logic                  w_rowEnd;
    logic                  w_frameEnd;
    logic                  w_mismatch;
    logic                  w_byteValid;
    logic [7:0]            w_byte;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_accept     = (r_state == ST_ACTIVE) && writeEnable;
    assign w_startFrame = (r_state == ST_IDLE) && start;
    assign w_rowEnd     = (r_expX == LAST_X);
    assign w_frameEnd   = w_rowEnd && (r_expY == LAST_Y);
    assign w_mismatch   = (xMedianAddress != r_expX) || (yMedianAddress != r_expY);
    assign w_addr       = r_rowBase + ADDR_WIDTH'(r_expX[7:3]);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_nextState = ST_ACTIVE;
            ST_ACTIVE: if (w_accept && w_frameEnd) w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // Placement comes only from these counters; incoming coordinates are
    // compared against them but never steer where a pixel lands.
    always_ff @(posedge clk) begin
        if (reset || w_startFrame) begin
            r_expX    <= '0;
            r_expY    <= '0;
            r_rowBase <= '0;
        end else if (w_accept) begin
            if (w_rowEnd) begin
                r_expX    <= '0;
                r_expY    <= r_expY + 8'd1;
                r_rowBase <= r_rowBase + ROW_STEP;
            end else begin
                r_expX <= r_expX + 8'd1;
            end
        end
    end

    pixel_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_startFrame),
        .i_shift     (w_accept),
        .i_bit       (dataIn),
        .i_flush     (w_rowEnd),
        .o_byteValid (w_byteValid),
        .o_byte      (w_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            memWriteEnable <= 1'b0;
            memAddress     <= '0;
            memData        <= '0;
            frameDone      <= 1'b0;
        end else begin
            memWriteEnable <= w_accept && w_byteValid;
            frameDone      <= w_accept && w_frameEnd;
            if (w_accept && w_byteValid) begin
                memAddress <= w_addr;
                memData    <= w_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_startFrame)        sequenceError <= 1'b0;
        else if (w_accept && w_mismatch)  sequenceError <= 1'b1;
    end

    assign busy = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_median_writeback.sv
// Scoreboard bench: a reduced-frame instance (10x3 output) and a default
// 238x178 instance, both checked against a beat-indexed byte model.
module tb_median_writeback;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int     addr;
        int     data;
        bit     fd;
        longint cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int OW[2]  = '{10, 238};
    int OH[2]  = '{3, 178};
    int BPR[2] = '{2, 30};

    bit act[2];
    int nb[2];
    int acc[2];

    logic        st[2], we[2], din[2];
    logic [7:0]  xa[2], ya[2];
    logic        mwe[2], busy[2], fdone[2], serr[2];
    logic [12:0] maddr[2];
    logic [7:0]  mdat[2];

    median_writeback #(.WINDOW_SIZE(3), .IMAGE_WIDTH(12), .IMAGE_HEIGHT(5), .ADDR_WIDTH(13)) u_small (
        .clk(clk), .reset(reset), .start(st[0]), .writeEnable(we[0]),
        .xMedianAddress(xa[0]), .yMedianAddress(ya[0]), .dataIn(din[0]),
        .memWriteEnable(mwe[0]), .memAddress(maddr[0]), .memData(mdat[0]),
        .busy(busy[0]), .frameDone(fdone[0]), .sequenceError(serr[0])
    );

    median_writeback u_big (
        .clk(clk), .reset(reset), .start(st[1]), .writeEnable(we[1]),
        .xMedianAddress(xa[1]), .yMedianAddress(ya[1]), .dataIn(din[1]),
        .memWriteEnable(mwe[1]), .memAddress(maddr[1]), .memData(mdat[1]),
        .busy(busy[1]), .frameDone(fdone[1]), .sequenceError(serr[1])
    );

    task automatic chk(input string nm, input longint act_v, input longint exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act_v, act_v, exp_v, exp_v);
        end
    endtask

    // Reference: the n-th accepted beat of a frame is pixel (n mod W, n / W);
    // byte k of row y holds pixels 8k..8k+7 with the leftmost in bit 0.
    task automatic model_beat(input int d, input int b);
        int   x, y;
        exp_t e;
        if (!act[d]) return;
        x = nb[d] % OW[d];
        y = nb[d] / OW[d];
        acc[d] |= (b & 1) << (x % 8);
        if ((x % 8 == 7) || (x == OW[d] - 1)) begin
            e.addr = y * BPR[d] + x / 8;
            e.data = acc[d];
            e.fd   = (nb[d] == OW[d] * OH[d] - 1);
            e.cyc  = cyc + 1;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            acc[d] = 0;
            if (e.fd) act[d] = 1'b0;
        end
        nb[d]++;
    endtask

    task automatic drive(input int d, input bit s, input bit w, input bit b, input int x, input int y);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0;
            we[k] = 1'b0;
        end
        st[d]  = s;
        we[d]  = w;
        din[d] = b;
        xa[d]  = 8'(x);
        ya[d]  = 8'(y);
        if (w) model_beat(d, int'(b));
        if (s && !act[d]) begin
            act[d] = 1'b1;
            nb[d]  = 0;
            acc[d] = 0;
        end
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    task automatic check_reset_vals(input int d);
        chk("rst_memWriteEnable", mwe[d], 0);
        chk("rst_memAddress", maddr[d], 0);
        chk("rst_memData", mdat[d], 0);
        chk("rst_busy", busy[d], 0);
        chk("rst_frameDone", fdone[d], 0);
        chk("rst_sequenceError", serr[d], 0);
    endtask

    // pat: 0 all ones, 1 x[0], 2 random; gap < 0 picks a random gap per beat.
    task automatic frame(input int d, input int pat, input int gap, input int bad, input int mid);
        int x, y, g;
        bit b;
        drive(d, 1, 0, 0, 0, 0);
        for (int n = 0; n < OW[d] * OH[d]; n++) begin
            x = n % OW[d];
            y = n / OW[d];
            b = (pat == 0) ? 1'b1 : (pat == 1) ? x[0] : 1'($urandom);
            drive(d, (n == mid), 1, b, (n == bad) ? (x ^ 4) : x, y);
            if (n == 0) begin
                chk("busy_after_start", busy[d], 1);
                chk("serr_clear_on_start", serr[d], 0);
            end
            if (n == bad) chk("serr_before_bad", serr[d], 0);
            g = (gap < 0) ? $urandom_range(3, 0) : gap;
            repeat (g) drive(d, 0, 0, 0, 0, 0);
        end
        drain();
        chk("busy_after_frame", busy[d], 0);
        chk("serr_after_frame", serr[d], (bad >= 0) ? 1 : 0);
    endtask

    int wr1 = 0, fd1 = 0, n3f = 0, last1 = -1, fd0 = 0;

    always @(negedge clk) begin
        exp_t e;
        if (fdone[0] && !mwe[0]) chk("done0_without_write", 1, 0);
        if (mwe[0]) begin
            if (q0.size() == 0) chk("unexpected_write0", maddr[0], -1);
            else begin
                e = q0.pop_front();
                chk("addr0", maddr[0], e.addr);
                chk("data0", mdat[0], e.data);
                chk("done0", fdone[0], e.fd);
                chk("latency0", cyc, e.cyc);
            end
            if (fdone[0]) begin
                fd0++;
                chk("busy_at_done0", busy[0], 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (fdone[1] && !mwe[1]) chk("done1_without_write", 1, 0);
        if (fdone[1]) fd1++;
        if (mwe[1]) begin
            wr1++;
            last1 = int'(maddr[1]);
            if (maddr[1] % 30 == 29 && mdat[1] == 8'h3F) n3f++;
            if (q1.size() == 0) chk("unexpected_write1", maddr[1], -1);
            else begin
                e = q1.pop_front();
                chk("addr1", maddr[1], e.addr);
                chk("data1", mdat[1], e.data);
                chk("done1", fdone[1], e.fd);
                chk("latency1", cyc, e.cyc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            st[k] = 0; we[k] = 0; din[k] = 0; xa[k] = 0; ya[k] = 0;
            act[k] = 0; nb[k] = 0; acc[k] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        reset = 1'b0;

        frame(0, 0, 0, -1, -1);           // all ones: FF,03 per row
        frame(0, 1, 0, -1, -1);           // x[0]: AA,02 per row
        frame(0, 1, 8, -1, -1);           // beats 9 cycles apart
        frame(0, 2, 0, 13, -1);           // row 1 beat 3 sent with x=7
        chk("serr_sticky_idle", serr[0], 1);
        frame(0, 2, -1, -1, -1);          // restart clears the flag

        // reset after 5 beats of row 0 discards the partial byte
        drive(0, 1, 0, 0, 0, 0);
        for (int n = 0; n < 5; n++) drive(0, 0, 1, 1, n, 0);
        @(negedge clk);
        we[0] = 0;
        reset = 1'b1;
        act[0] = 0;
        acc[0] = 0;
        repeat (2) @(negedge clk);
        check_reset_vals(0);
        reset = 1'b0;
        frame(0, 0, 0, -1, -1);

        // writeEnable in IDLE, then start pulsed mid-frame
        for (int n = 0; n < 3; n++) drive(0, 0, 1, 1, n, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("idle_we_busy", busy[0], 0);
        chk("idle_we_serr", serr[0], 0);
        chk("idle_we_nowrite", q0.size(), 0);
        frame(0, 2, 0, -1, 4);

        for (int r = 0; r < 3; r++) frame(0, 2, -1, -1, -1);
        chk("small_frame_count", fd0, 10);

        frame(1, 0, 0, -1, -1);
        chk("big_writes", wr1, 5340);
        chk("big_last_addr", last1, 5339);
        chk("big_row_end_3F", n3f, 178);
        chk("big_frameDone_pulses", fd1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
